// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Sequencing controller for the three-stage core (IF -> DE/EX -> MW).
// Sits beside the DE/EX datapath and:
//   - decodes the immediate format for the immediate generator,
//   - redirects the PC and flushes IF/DE on taken branches and jumps,
//   - tracks the memory operation in MW and stalls the front of the pipe
//     until data memory acknowledges, abandoning the access after
//     TIMEOUT_CYCLES wait cycles and latching a sticky error.
//
// Parameters:
//   TIMEOUT_CYCLES  wait cycles tolerated without dmem_ack (1..1023)
//
// Ports:
//   clk        in   core clock
//   rst        in   synchronous active-high reset
//   inst_de    in   instruction currently in DE/EX
//   valid_de   in   inst_de is a real instruction (not a bubble)
//   br_taken   in   branch comparator result for inst_de
//   dmem_ack   in   data memory completes the MW access this cycle
//   imm_type   out  immediate format: 000 I, 001 J, 010 U, 011 B, 100 S
//   pc_sel     out  PC takes branch/jump target
//   flush_de   out  IF/DE register loads a bubble
//   stall_if   out  hold PC and IF/DE register
//   stall_de   out  hold DE/MW register
//   dmem_req   out  MW-stage memory access pending
//   mem_err    out  sticky, an access timed out
//   stall_cnt  out  cycles with stall_if high   (PIPE_CTRL_PERF_EN only)
//   flush_cnt  out  cycles with flush_de high   (PIPE_CTRL_PERF_EN only)
//
// Build option:
//   PIPE_CTRL_PERF_EN  adds the two 32-bit wrapping performance counters.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_de,
  input  logic        valid_de,
  input  logic        br_taken,
  input  logic        dmem_ack,
  output logic [2:0]  imm_type,
  output logic        pc_sel,
  output logic        flush_de,
  output logic        stall_if,
  output logic        stall_de,
  output logic        dmem_req,
  output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_J = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_S = 3'b100;

  localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT_CYCLES);
  localparam logic [9:0] CNT_MAX     = 10'h3FF;

  state_t      state_q, state_d;
  logic [9:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;

  logic [6:0]  opcode;
  logic        mem_op;
  logic        redirect;
  logic        timeout;
  logic        unused_inst_bits;

  assign opcode           = inst_de[6:0];
  assign unused_inst_bits = ^inst_de[31:7];

  // Immediate format select, purely from the DE opcode
  always_comb begin
    imm_type = IMM_I;
    case (opcode)
      OP_JAL:             imm_type = IMM_J;
      OP_LUI, OP_AUIPC:   imm_type = IMM_U;
      OP_BRANCH:          imm_type = IMM_B;
      OP_STORE:           imm_type = IMM_S;
      default:            imm_type = IMM_I;
    endcase
  end

  assign mem_op   = valid_de && ((opcode == OP_LOAD) || (opcode == OP_STORE));
  assign redirect = valid_de && ((opcode == OP_JAL) || (opcode == OP_JALR) ||
                                 ((opcode == OP_BRANCH) && br_taken));

  // An ack in the same cycle as the limit wins: the access completed.
  assign timeout  = (state_q == MEM_WAIT) && !dmem_ack && (wait_cnt_q >= TIMEOUT_LIM);

  // Next-state and stall/request outputs. Finishing an access (ack or
  // timeout) lets the pipe advance, so a mem_op sitting in DE at that
  // moment moves straight into MW and starts a fresh wait.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    stall_if   = 1'b0;
    stall_de   = 1'b0;
    dmem_req   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_op) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack || timeout) begin
          dmem_req = dmem_ack;
          if (timeout) begin
            mem_err_d = 1'b1;
          end
          if (mem_op) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = '0;
          end else begin
            state_d = RUN;
          end
        end else begin
          dmem_req = 1'b1;
          stall_if = 1'b1;
          stall_de = 1'b1;
          if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 10'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // A stalled branch/jump is held in DE and redirects once it advances
  assign pc_sel   = redirect && !stall_if;
  assign flush_de = redirect && !stall_if;
  assign mem_err  = mem_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters, wrapping modulo 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_if) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_de) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed, table-driven bench for pipe_ctrl built with TIMEOUT_CYCLES = 4.
// Each record is one clock cycle: inputs held for that cycle and the
// outputs expected during it. Inputs change just after the falling edge
// and outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int NVEC = 29;

  // ctl  = {valid_de, br_taken, dmem_ack, rst}
  // outs = {pc_sel, flush_de, stall_if, stall_de, dmem_req, mem_err}
  typedef struct packed {
    logic [31:0] inst;
    logic [3:0]  ctl;
    logic [2:0]  imm;
    logic [5:0]  outs;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] inst_de;
  logic        valid_de;
  logic        br_taken;
  logic        dmem_ack;
  logic [2:0]  imm_type;
  logic        pc_sel;
  logic        flush_de;
  logic        stall_if;
  logic        stall_de;
  logic        dmem_req;
  logic        mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  vec_t vecs [NVEC];

  pipe_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .inst_de  (inst_de),
    .valid_de (valid_de),
    .br_taken (br_taken),
    .dmem_ack (dmem_ack),
    .imm_type (imm_type),
    .pc_sel   (pc_sel),
    .flush_de (flush_de),
    .stall_if (stall_if),
    .stall_de (stall_de),
    .dmem_req (dmem_req),
    .mem_err  (mem_err)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the falling edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    inst_de = v.inst;
    {valid_de, br_taken, dmem_ack, rst} = v.ctl;
    #1;
  endtask

  // Compare the whole output bundle against the record's expectation
  task automatic checkOutput(input vec_t v, input string name);
    logic [8:0] got;
    logic [8:0] exp;
    got = {imm_type, pc_sel, flush_de, stall_if, stall_de, dmem_req, mem_err};
    exp = {v.imm, v.outs};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got imm/pc/fl/sif/sde/req/err=%b required=%b", name, got, exp);
    end
  endtask

  task automatic runVec(input vec_t v, input string name);
    applyStimulus(v);
    checkOutput(v, name);
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask
`endif

  initial begin
    int exp_stall;
    int exp_flush;

    // Reset check, immediate decode sweep, redirects
    vecs[0]  = '{32'h13, 4'b1001, 3'd0, 6'b000000};
    vecs[1]  = '{32'h6F, 4'b0000, 3'd1, 6'b000000};
    vecs[2]  = '{32'h37, 4'b1000, 3'd2, 6'b000000};
    vecs[3]  = '{32'h17, 4'b1000, 3'd2, 6'b000000};
    vecs[4]  = '{32'h63, 4'b1000, 3'd3, 6'b000000};
    vecs[5]  = '{32'h23, 4'b0000, 3'd4, 6'b000000};
    vecs[6]  = '{32'h33, 4'b1000, 3'd0, 6'b000000};
    vecs[7]  = '{32'h63, 4'b1100, 3'd3, 6'b110000};
    vecs[8]  = '{32'h13, 4'b1000, 3'd0, 6'b000000};
    vecs[9]  = '{32'h6F, 4'b1000, 3'd1, 6'b110000};
    vecs[10] = '{32'h67, 4'b1000, 3'd0, 6'b110000};
    // Zero-wait load
    vecs[11] = '{32'h03, 4'b1000, 3'd0, 6'b000000};
    vecs[12] = '{32'h13, 4'b1010, 3'd0, 6'b000010};
    vecs[13] = '{32'h13, 4'b1000, 3'd0, 6'b000000};
    // Store with ack in the 4th request cycle
    vecs[14] = '{32'h23, 4'b1000, 3'd4, 6'b000000};
    vecs[15] = '{32'h13, 4'b1000, 3'd0, 6'b001110};
    vecs[16] = '{32'h13, 4'b1000, 3'd0, 6'b001110};
    vecs[17] = '{32'h13, 4'b1000, 3'd0, 6'b001110};
    vecs[18] = '{32'h13, 4'b1010, 3'd0, 6'b000010};
    vecs[19] = '{32'h13, 4'b1000, 3'd0, 6'b000000};
    // Taken branch held behind a 2-cycle load wait
    vecs[20] = '{32'h03, 4'b1000, 3'd0, 6'b000000};
    vecs[21] = '{32'h63, 4'b1100, 3'd3, 6'b001110};
    vecs[22] = '{32'h63, 4'b1100, 3'd3, 6'b001110};
    vecs[23] = '{32'h63, 4'b1110, 3'd3, 6'b110010};
    vecs[24] = '{32'h13, 4'b1000, 3'd0, 6'b000000};
    // Back-to-back memory ops
    vecs[25] = '{32'h03, 4'b1000, 3'd0, 6'b000000};
    vecs[26] = '{32'h23, 4'b1010, 3'd4, 6'b000010};
    vecs[27] = '{32'h13, 4'b1010, 3'd0, 6'b000010};
    vecs[28] = '{32'h13, 4'b1000, 3'd0, 6'b000000};

    rst      = 1'b1;
    inst_de  = 32'h13;
    valid_de = 1'b0;
    br_taken = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef PIPE_CTRL_PERF_EN
    // Counters have seen every edge after the reset row except the last row's
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 1; i < NVEC - 1; i++) begin
      if (vecs[i].outs[3]) exp_stall++;
      if (vecs[i].outs[4]) exp_flush++;
    end
    checkCount("stall_cnt_table", stall_cnt, 32'(exp_stall));
    checkCount("flush_cnt_table", flush_cnt, 32'(exp_flush));
`else
    exp_stall = 0;
    exp_flush = 0;
`endif

    // Timeout with dmem_ack held low (limit 4), then sticky error until reset
    runVec('{32'h13, 4'b1001, 3'd0, 6'b000000}, "to_reset");
    runVec('{32'h03, 4'b1000, 3'd0, 6'b000000}, "to_load");
    for (int w = 0; w < 4; w++) begin
      runVec('{32'h13, 4'b1000, 3'd0, 6'b001110}, $sformatf("to_wait%0d", w));
    end
    runVec('{32'h13, 4'b1000, 3'd0, 6'b000000}, "to_abandon");
    runVec('{32'h13, 4'b1000, 3'd0, 6'b000001}, "to_err_set");
    runVec('{32'h63, 4'b1100, 3'd3, 6'b110001}, "to_err_branch");
    runVec('{32'h03, 4'b1000, 3'd0, 6'b000001}, "to_err_load");
    runVec('{32'h13, 4'b1010, 3'd0, 6'b000011}, "to_err_ack");
    runVec('{32'h13, 4'b1001, 3'd0, 6'b000001}, "to_err_in_reset");
    runVec('{32'h13, 4'b1000, 3'd0, 6'b000000}, "to_err_cleared");

    // Reset asserted in the 2nd wait cycle, with a taken branch held in DE
    runVec('{32'h03, 4'b1000, 3'd0, 6'b000000}, "rm_load");
    runVec('{32'h63, 4'b1100, 3'd3, 6'b001110}, "rm_wait1");
    runVec('{32'h63, 4'b1101, 3'd3, 6'b001110}, "rm_wait2_reset");
    runVec('{32'h13, 4'b1000, 3'd0, 6'b000000}, "rm_after_reset");
`ifdef PIPE_CTRL_PERF_EN
    checkCount("stall_cnt_reset", stall_cnt, 32'd0);
    checkCount("flush_cnt_reset", flush_cnt, 32'd0);
`endif
    runVec('{32'h13, 4'b1000, 3'd0, 6'b000000}, "rm_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
